kernel_window_ctrl: RTL and testbench

Streaming window controller in front of the 3x3 kernel filter. It accepts a raster-order pixel stream for one IMG_W x IMG_H frame and keeps two line buffers plus a 3x3 shift window. It issues one valid-qualified window per interior pixel position to the filter, together with the kernel select latched at frame start. It counts the filter's result pulses and signals frame completion, so one frame is sequenced end-to-end per start command.

---
 rtl/kernel_window_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_kernel_window_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_window_ctrl.sv
// kernel_window_ctrl: line-buffered 3x3 window sequencer for the kernel filter.
// Optional `KWC_FRAME_CNT_EN adds a 16-bit wrapping completed-frame counter.
module kernel_window_ctrl #(
  parameter int DATA_SIZE  = 8,
  parameter int IMG_W      = 16,
  parameter int IMG_H      = 16,
  parameter int KERNEL_SEL = 2
) (
  input  logic                              i_clk,
  input  logic                              i_nrst,
  input  logic                              i_start,
  input  logic [KERNEL_SEL-1:0]             i_cfg_sel,
  input  logic                              i_pix_valid,
  input  logic [DATA_SIZE-1:0]              i_pix_data,
  output logic                              o_pix_ready,
  output logic                              o_flt_valid,
  output logic [2:0][2:0][DATA_SIZE-1:0]    o_flt_window,
  output logic [KERNEL_SEL-1:0]             o_flt_cfg,
  input  logic                              i_flt_res_valid,
  output logic                              o_busy,
  output logic                              o_frame_done
`ifdef KWC_FRAME_CNT_EN
  ,
  output logic [15:0]                       o_frame_cnt
`endif
);

  localparam int RES_MAX = (IMG_W - 2) * (IMG_H - 2);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int NW = $clog2(RES_MAX + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [NW-1:0] RES_TGT  = NW'(RES_MAX);

  typedef logic [2:0][2:0][DATA_SIZE-1:0] win_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [KERNEL_SEL-1:0] cfg_q, cfg_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [NW-1:0]         res_q, res_d;
  win_t                  win_q, win_d;
  win_t                  owin_q, owin_d;
  logic                  fvalid_q, fvalid_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  xfer;

  logic [DATA_SIZE-1:0]  lb0_q [IMG_W];
  logic [DATA_SIZE-1:0]  lb1_q [IMG_W];

  // Next-state, counters, window shift and registered output decode.
  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    col_d    = col_q;
    row_d    = row_q;
    res_d    = res_q;
    win_d    = win_q;
    owin_d   = owin_q;
    fvalid_d = 1'b0;
    xfer     = ready_q & i_pix_valid;

    if ((state_q == S_RUN || state_q == S_DRAIN) &&
        i_flt_res_valid && res_q != RES_TGT) begin
      res_d = res_q + NW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_RUN;
          cfg_d   = i_cfg_sel;
          col_d   = '0;
          row_d   = '0;
          res_d   = '0;
        end
      end
      S_RUN: begin
        if (xfer) begin
          for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
          end
          win_d[0][2] = lb1_q[col_q];
          win_d[1][2] = lb0_q[col_q];
          win_d[2][2] = i_pix_data;
          if (row_q >= RW'(2) && col_q >= CW'(2)) begin
            fvalid_d = 1'b1;
            owin_d   = win_d;
          end
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + RW'(1);
            if (row_q == ROW_LAST) state_d = S_DRAIN;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (res_d == RES_TGT) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_RUN);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // Control state, counters, shift window and output registers.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q  <= S_IDLE;
      cfg_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      res_q    <= '0;
      win_q    <= '0;
      owin_q   <= '0;
      fvalid_q <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      col_q    <= col_d;
      row_q    <= row_d;
      res_q    <= res_d;
      win_q    <= win_d;
      owin_q   <= owin_d;
      fvalid_q <= fvalid_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Line buffers hold the two previous rows; stale data never reaches a window.
  always_ff @(posedge i_clk) begin
    if (state_q == S_RUN && xfer) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= i_pix_data;
    end
  end

`ifdef KWC_FRAME_CNT_EN
  logic [15:0] fcnt_q, fcnt_d;

  // Completed-frame counter, wraps naturally at 16 bits.
  always_comb begin
    fcnt_d = fcnt_q;
    if (done_d) fcnt_d = fcnt_q + 16'd1;
  end

  // Frame counter register.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) fcnt_q <= '0;
    else         fcnt_q <= fcnt_d;
  end

  assign o_frame_cnt = fcnt_q;
`endif

  assign o_pix_ready  = ready_q;
  assign o_flt_valid  = fvalid_q;
  assign o_flt_window = owin_q;
  assign o_flt_cfg    = cfg_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_kernel_window_ctrl.sv
// tb_kernel_window_ctrl: scoreboard bench for a 4x4 frame window controller.
// Expected windows come from frame-array index arithmetic.
module tb_kernel_window_ctrl;

  localparam int W = 4;
  localparam int H = 4;

  logic                   i_clk = 1'b0;
  logic                   i_nrst = 1'b0;
  logic                   i_start = 1'b0;
  logic [1:0]             i_cfg_sel = '0;
  logic                   i_pix_valid = 1'b0;
  logic [7:0]             i_pix_data = '0;
  logic                   o_pix_ready;
  logic                   o_flt_valid;
  logic [2:0][2:0][7:0]   o_flt_window;
  logic [1:0]             o_flt_cfg;
  logic                   i_flt_res_valid;
  logic                   o_busy;
  logic                   o_frame_done;
`ifdef KWC_FRAME_CNT_EN
  logic [15:0]            o_frame_cnt;
`endif

  kernel_window_ctrl #(
    .DATA_SIZE(8), .IMG_W(W), .IMG_H(H), .KERNEL_SEL(2)
  ) dut (
    .i_clk(i_clk),
    .i_nrst(i_nrst),
    .i_start(i_start),
    .i_cfg_sel(i_cfg_sel),
    .i_pix_valid(i_pix_valid),
    .i_pix_data(i_pix_data),
    .o_pix_ready(o_pix_ready),
    .o_flt_valid(o_flt_valid),
    .o_flt_window(o_flt_window),
    .o_flt_cfg(o_flt_cfg),
    .i_flt_res_valid(i_flt_res_valid),
    .o_busy(o_busy),
    .o_frame_done(o_frame_done)
`ifdef KWC_FRAME_CNT_EN
    ,
    .o_frame_cnt(o_frame_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [71:0] w;
    logic [1:0]  cfg;
  } exp_t;

  exp_t       win_q[$];
  int         done_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         frames = 0;
  logic [7:0] frame [W*H];
  logic [1:0] cur_cfg;
  logic [1:0] pipe = '0;
  logic       extra_res = 1'b0;
  logic       prev_xfer = 1'b0;
  logic       prev_done = 1'b0;

  // Filter model: result strobe two cycles after each window.
  always @(posedge i_clk) pipe <= {pipe[0], o_flt_valid};
  assign i_flt_res_valid = pipe[1] | extra_res;

  task automatic chk(input string nm, input logic [71:0] act,
                     input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  always @(negedge i_clk) begin
    exp_t e;
    cyc++;
    if (o_flt_valid) begin
      chk("no_gap_window", 72'(prev_xfer), 72'd1);
      if (win_q.size() == 0) begin
        chk("unexpected_window", 72'd1, 72'd0);
      end else begin
        e = win_q.pop_front();
        chk("window", o_flt_window, e.w);
        chk("cfg", 72'(o_flt_cfg), 72'(e.cfg));
      end
    end
    if (o_frame_done) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 72'd1, 72'd0);
      end else begin
        chk("done_cycle", 72'(cyc), 72'(done_q.pop_front()));
      end
    end
    if (prev_done) begin
      chk("busy_after_done", 72'(o_busy), 72'd0);
`ifdef KWC_FRAME_CNT_EN
      chk("frame_cnt", 72'(o_frame_cnt), 72'(frames));
`endif
    end
    if (o_frame_done) frames++;
    prev_xfer = i_pix_valid && o_pix_ready;
    prev_done = o_frame_done;
  end

  task automatic chk_reset_vals();
    chk("rst_ready", 72'(o_pix_ready), 72'd0);
    chk("rst_fvalid", 72'(o_flt_valid), 72'd0);
    chk("rst_busy", 72'(o_busy), 72'd0);
    chk("rst_done", 72'(o_frame_done), 72'd0);
    chk("rst_window", o_flt_window, 72'd0);
    chk("rst_cfg", 72'(o_flt_cfg), 72'd0);
  endtask

  task automatic start_frame(input logic [1:0] cfg);
    i_start   = 1'b1;
    i_cfg_sel = cfg;
    cur_cfg   = cfg;
    @(posedge i_clk); #1;
    i_start   = 1'b0;
    i_cfg_sel = 2'($urandom);
  endtask

  task automatic send(input int idx, input bit gap, input bit poke);
    bit acc;
    int guard;
    int r;
    int c;
    logic [2:0][2:0][7:0] ew;
    if (gap) begin
      i_pix_valid = 1'b0;
      @(posedge i_clk); #1;
    end
    i_pix_valid = 1'b1;
    i_pix_data  = frame[idx];
    i_start     = poke;
    i_cfg_sel   = poke ? 2'd0 : 2'($urandom);
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 50) begin
      @(negedge i_clk);
      acc = o_pix_ready;
      @(posedge i_clk); #1;
      guard++;
    end
    i_pix_valid = 1'b0;
    i_start     = 1'b0;
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: pixel %0d not accepted", idx);
      return;
    end
    r = idx / W;
    c = idx % W;
    if (r >= 2 && c >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          ew[i][j] = frame[(r - 2 + i) * W + (c - 2 + j)];
      win_q.push_back('{w: ew, cfg: cur_cfg});
    end
    if (idx == W * H - 1) done_q.push_back(cyc + 4);
  endtask

  task automatic wait_done();
    int guard = 0;
    while (done_q.size() != 0 && guard < 200) begin
      @(posedge i_clk); #1;
      guard++;
    end
    if (done_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: %0d completions outstanding", done_q.size());
      done_q.delete();
    end
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
  endtask

  // mode 0: 0..15, 1: 100..115, 2: random; gap 0 none, 1 alternate, 2 random
  task automatic run_frame(input int mode, input logic [1:0] cfg,
                           input int gap, input bit poke);
    for (int k = 0; k < W * H; k++)
      frame[k] = (mode == 0) ? 8'(k) :
                 (mode == 1) ? 8'(100 + k) : 8'($urandom_range(0, 255));
    start_frame(cfg);
    for (int k = 0; k < W * H; k++) begin
      bit g;
      g = (gap == 1) ? 1'b1 :
          (gap == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
      send(k, g, poke && k == 7);
    end
    if (poke) begin
      i_start   = 1'b1;
      i_cfg_sel = 2'd0;
      @(posedge i_clk); #1;
      i_start = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    #2;
    @(negedge i_clk);
    chk_reset_vals();
    @(posedge i_clk); #1;
    i_nrst = 1'b1;
    @(posedge i_clk); #1;

    run_frame(0, 2'd2, 0, 1'b0);
    run_frame(0, 2'd2, 1, 1'b0);
    run_frame(0, 2'd2, 0, 1'b1);

    extra_res = 1'b1;
    repeat (3) begin
      @(posedge i_clk); #1;
    end
    extra_res = 1'b0;
    run_frame(2, 2'd1, 0, 1'b0);

    for (int k = 0; k < W * H; k++) frame[k] = 8'(k);
    start_frame(2'd3);
    for (int k = 0; k < 10; k++) send(k, 1'b0, 1'b0);
    i_nrst = 1'b0;
    @(negedge i_clk);
    chk_reset_vals();
    @(posedge i_clk); #1;
    i_nrst = 1'b1;
    @(posedge i_clk); #1;
    run_frame(1, 2'd2, 0, 1'b0);

    for (int f = 0; f < 4; f++)
      run_frame(2, 2'($urandom), 2, f[0]);

    repeat (5) begin
      @(posedge i_clk); #1;
    end
    chk("leftover_windows", 72'(win_q.size()), 72'd0);
    chk("leftover_done", 72'(done_q.size()), 72'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
